// File: rtl/huff_pair_decoder.sv
// Serial Huffman big-value pair decoder: one bitstream bit per beat, external codebook LUT,
// linbits escape and sign handling, (x, y) pair out over valid/ready. Optional flush port: HUFF_FLUSH_EN.
module huff_pair_decoder #(
   parameter int unsigned MAX_BITS = 19,
   parameter int unsigned LIN_MAX  = 13,
   parameter int unsigned OUT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
`ifdef HUFF_FLUSH_EN
   input  logic                flush,
`endif
   input  logic                s_valid,
   input  logic                s_data,
   output logic                s_ready,
   input  logic [3:0]          linbits,
   output logic [4:0]          lut_len,
   output logic [MAX_BITS-1:0] lut_code,
   input  logic                lut_found,
   input  logic [3:0]          lut_x,
   input  logic [3:0]          lut_y,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [OUT_W-1:0]    x_val,
   output logic [OUT_W-1:0]    y_val,
   output logic                err_overlong,
   output logic [15:0]         pair_count
);

   localparam int unsigned LEN_W = 5;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned LIN_W = LIN_MAX;

   typedef enum logic [2:0] {S_CODE, S_XLIN, S_XSIGN, S_YLIN, S_YSIGN, S_OUT} state_e;

   state_e               state_q, state_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic [MAX_BITS-1:0]  code_q, code_d;
   logic [3:0]           xa_q, xa_d, ya_q, ya_d, lb_q, lb_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [LIN_W-1:0]     xlin_q, xlin_d, ylin_q, ylin_d;
   logic                 xs_q, xs_d, ys_q, ys_d;
   logic                 m_valid_q, m_valid_d, err_q, err_d;
   logic [OUT_W-1:0]     x_val_q, x_val_d, y_val_q, y_val_d;
   logic [15:0]          pair_count_q, pair_count_d;
   logic [3:0]           lb_sat;

   // Next state once the x component (if any) has been fully read
   function automatic state_e after_x(input logic [3:0] y, input logic [3:0] lb);
      if (y == 4'd15 && lb != 4'd0) return S_YLIN;
      else if (y != 4'd0)           return S_YSIGN;
      else                          return S_OUT;
   endfunction

   function automatic state_e after_code(input logic [3:0] x, input logic [3:0] y, input logic [3:0] lb);
      if (x == 4'd15 && lb != 4'd0) return S_XLIN;
      else if (x != 4'd0)           return S_XSIGN;
      else                          return after_x(y, lb);
   endfunction

   function automatic logic [OUT_W-1:0] signed_val(input logic [3:0] a, input logic [LIN_W-1:0] lin,
                                                   input logic neg);
      logic [OUT_W-1:0] mag;
      mag = OUT_W'(a) + OUT_W'(lin);
      return neg ? OUT_W'(0) - mag : mag;
   endfunction

   assign lb_sat = (32'(linbits) > LIN_MAX) ? 4'(LIN_MAX) : linbits;

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      code_d       = code_q;
      xa_d         = xa_q;
      ya_d         = ya_q;
      lb_d         = lb_q;
      cnt_d        = cnt_q;
      xlin_d       = xlin_q;
      ylin_d       = ylin_q;
      xs_d         = xs_q;
      ys_d         = ys_q;
      m_valid_d    = m_valid_q;
      x_val_d      = x_val_q;
      y_val_d      = y_val_q;
      err_d        = 1'b0;
      pair_count_d = pair_count_q;
      s_ready      = 1'b0;

      case (state_q)
         S_CODE: begin
            if (len_q != LEN_W'(0) && lut_found) begin
               xa_d    = lut_x;
               ya_d    = lut_y;
               lb_d    = lb_sat;
               len_d   = LEN_W'(0);
               code_d  = '0;
               cnt_d   = CNT_W'(0);
               xlin_d  = '0;
               ylin_d  = '0;
               xs_d    = 1'b0;
               ys_d    = 1'b0;
               state_d = after_code(lut_x, lut_y, lb_sat);
            end else if (len_q == LEN_W'(MAX_BITS)) begin
               // No codeword matched: drop the accumulated bits and resync
               err_d  = 1'b1;
               len_d  = LEN_W'(0);
               code_d = '0;
            end else begin
               s_ready = 1'b1;
               if (s_valid) begin
                  for (int i = 0; i < MAX_BITS; i++)
                     if (LEN_W'(MAX_BITS - 1 - i) == len_q) code_d[i] = s_data;
                  len_d = len_q + LEN_W'(1);
               end
            end
         end
         S_XLIN: begin
            s_ready = 1'b1;
            if (s_valid) begin
               xlin_d = {xlin_q[LIN_W-2:0], s_data};
               cnt_d  = cnt_q + CNT_W'(1);
               if (cnt_q + CNT_W'(1) == lb_q) begin
                  cnt_d   = CNT_W'(0);
                  state_d = S_XSIGN;
               end
            end
         end
         S_XSIGN: begin
            s_ready = 1'b1;
            if (s_valid) begin
               xs_d    = s_data;
               state_d = after_x(ya_q, lb_q);
            end
         end
         S_YLIN: begin
            s_ready = 1'b1;
            if (s_valid) begin
               ylin_d = {ylin_q[LIN_W-2:0], s_data};
               cnt_d  = cnt_q + CNT_W'(1);
               if (cnt_q + CNT_W'(1) == lb_q) begin
                  cnt_d   = CNT_W'(0);
                  state_d = S_YSIGN;
               end
            end
         end
         S_YSIGN: begin
            s_ready = 1'b1;
            if (s_valid) begin
               ys_d    = s_data;
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            if (m_ready) begin
               m_valid_d    = 1'b0;
               pair_count_d = pair_count_q + 16'd1;
               state_d      = S_CODE;
            end
         end
         default: state_d = S_CODE;
      endcase

`ifdef HUFF_FLUSH_EN
      // Flush abandons a partial pair but never a pair already presented
      if (flush && state_q != S_OUT) begin
         s_ready = 1'b0;
         state_d = S_CODE;
         len_d   = LEN_W'(0);
         code_d  = '0;
         cnt_d   = CNT_W'(0);
         xlin_d  = '0;
         ylin_d  = '0;
         xs_d    = 1'b0;
         ys_d    = 1'b0;
         err_d   = 1'b0;
      end
`endif

      if (state_q != S_OUT && state_d == S_OUT) begin
         m_valid_d = 1'b1;
         x_val_d   = signed_val(xa_d, xlin_d, xs_d);
         y_val_d   = signed_val(ya_d, ylin_d, ys_d);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_CODE;
         len_q        <= '0;
         code_q       <= '0;
         xa_q         <= '0;
         ya_q         <= '0;
         lb_q         <= '0;
         cnt_q        <= '0;
         xlin_q       <= '0;
         ylin_q       <= '0;
         xs_q         <= 1'b0;
         ys_q         <= 1'b0;
         m_valid_q    <= 1'b0;
         x_val_q      <= '0;
         y_val_q      <= '0;
         err_q        <= 1'b0;
         pair_count_q <= '0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         code_q       <= code_d;
         xa_q         <= xa_d;
         ya_q         <= ya_d;
         lb_q         <= lb_d;
         cnt_q        <= cnt_d;
         xlin_q       <= xlin_d;
         ylin_q       <= ylin_d;
         xs_q         <= xs_d;
         ys_q         <= ys_d;
         m_valid_q    <= m_valid_d;
         x_val_q      <= x_val_d;
         y_val_q      <= y_val_d;
         err_q        <= err_d;
         pair_count_q <= pair_count_d;
      end
   end

   assign lut_len      = len_q;
   assign lut_code     = code_q;
   assign m_valid      = m_valid_q;
   assign x_val        = x_val_q;
   assign y_val        = y_val_q;
   assign err_overlong = err_q;
   assign pair_count   = pair_count_q;

endmodule

// File: tb/tb_huff_pair_decoder.sv
// Scoreboard bench for huff_pair_decoder with a small four-entry codebook LUT model.
module tb_huff_pair_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid, s_data, s_ready;
   logic [3:0]  linbits;
   logic [4:0]  lut_len;
   logic [18:0] lut_code;
   logic        lut_found;
   logic [3:0]  lut_x, lut_y;
   logic        m_valid, m_ready;
   logic [15:0] x_val, y_val;
   logic        err_overlong;
   logic [15:0] pair_count;
   logic        force_miss;

   int          pass_cnt = 0;
   int          total_cnt = 0;
   int          bits_taken = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   huff_pair_decoder dut (
      .clk(clk), .rst(rst),
`ifdef HUFF_FLUSH_EN
      .flush(1'b0),
`endif
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .linbits(linbits),
      .lut_len(lut_len), .lut_code(lut_code), .lut_found(lut_found),
      .lut_x(lut_x), .lut_y(lut_y), .m_valid(m_valid), .m_ready(m_ready),
      .x_val(x_val), .y_val(y_val), .err_overlong(err_overlong), .pair_count(pair_count)
   );

   // Codebook: "1"->(0,0) "01"->(15,1) "001"->(1,15) "000"->(2,0)
   always_comb begin
      lut_found = 1'b0;
      lut_x     = 4'd0;
      lut_y     = 4'd0;
      if (!force_miss) begin
         if (lut_len == 5'd1 && lut_code[18] == 1'b1) begin
            lut_found = 1'b1;
         end else if (lut_len == 5'd2 && lut_code[18:17] == 2'b01) begin
            lut_found = 1'b1; lut_x = 4'd15; lut_y = 4'd1;
         end else if (lut_len == 5'd3 && lut_code[18:16] == 3'b001) begin
            lut_found = 1'b1; lut_x = 4'd1; lut_y = 4'd15;
         end else if (lut_len == 5'd3 && lut_code[18:16] == 3'b000) begin
            lut_found = 1'b1; lut_x = 4'd2;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge clk) if (!rst && s_valid && s_ready) bits_taken++;

   // Monitor: compare every delivered pair against the scoreboard
   int exp_pc = 0;
   always @(negedge clk) begin
      if (rst) exp_pc = 0;
      else if (m_valid && m_ready) begin
         if (exp_q.size() == 0) check("unexpected_pair", 32'd1, 32'd0);
         else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check("pair_x", 32'(x_val), 32'(e[31:16]));
            check("pair_y", 32'(y_val), 32'(e[15:0]));
            check("pair_count_at_handshake", 32'(pair_count), 32'(exp_pc));
            exp_pc++;
         end
      end
   end

   // Called just after a posedge; returns just after the edge that took the last bit
   task automatic send_bits(input logic [31:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         logic acc;
         int   t;
         acc = 1'b0;
         t   = 0;
         s_valid = 1'b1;
         s_data  = bits[i];
         while (!acc && t < 100) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk); #1;
            t++;
         end
         if (!acc) check("send_timeout", 32'd0, 32'd1);
      end
      s_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || m_valid) && t < 60) begin
         @(negedge clk);
         t++;
      end
      check(name, 32'(exp_q.size() == 0 && !m_valid), 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      int b0, errs;
      rst = 1'b1; s_valid = 1'b0; s_data = 1'b0; m_ready = 1'b1; linbits = 4'd0; force_miss = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_x_val", 32'(x_val), 32'd0);
      check("rst_y_val", 32'(y_val), 32'd0);
      check("rst_err", 32'(err_overlong), 32'd0);
      check("rst_pair_count", 32'(pair_count), 32'd0);
      check("rst_s_ready", 32'(s_ready), 32'd1);
      check("rst_lut_len", 32'(lut_len), 32'd0);
      @(posedge clk); #1;

      // Zero pair and its latency
      exp_q.push_back({16'h0000, 16'h0000});
      send_bits(32'b1, 1);
      @(negedge clk);
      check("lat_m_valid_1cyc", 32'(m_valid), 32'd0);
      @(negedge clk);
      check("lat_m_valid_2cyc", 32'(m_valid), 32'd1);
      wait_drain("drain_zero");
      check("pair_count_1", 32'(pair_count), 32'd1);

      // x escape with linbits=4: x=-(15+3), y=+1, 8 bits
      linbits = 4'd4;
      b0 = bits_taken;
      exp_q.push_back({16'hFFEE, 16'h0001});
      send_bits(32'b01_0011_1_0, 8);
      wait_drain("drain_esc4");
      check("esc4_bits_consumed", 32'(bits_taken - b0), 32'd8);

      // x=15 with linbits=0 is a plain value
      linbits = 4'd0;
      b0 = bits_taken;
      exp_q.push_back({16'h000F, 16'hFFFF});
      send_bits(32'b01_0_1, 4);
      wait_drain("drain_plain15");
      check("plain15_bits_consumed", 32'(bits_taken - b0), 32'd4);

      // linbits 15 saturates to 13: y=-(15+8191)
      linbits = 4'd15;
      exp_q.push_back({16'h0001, 16'hDFF2});
      send_bits(32'b001_0_1111111111111_1, 18);
      wait_drain("drain_sat");

      // Backpressure on pair (+2,0)
      linbits = 4'd0;
      m_ready = 1'b0;
      exp_q.push_back({16'h0002, 16'h0000});
      send_bits(32'b000_0, 4);
      s_valid = 1'b1; s_data = 1'b1;
      for (int t = 0; t < 20 && !m_valid; t++) @(negedge clk);
      check("bp_m_valid", 32'(m_valid), 32'd1);
      b0 = bits_taken;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_s_ready", 32'(s_ready), 32'd0);
         check("bp_x_hold", 32'(x_val), 32'd2);
         check("bp_y_hold", 32'(y_val), 32'd0);
      end
      check("bp_no_bits", 32'(bits_taken - b0), 32'd0);
      @(posedge clk); #1;
      s_valid = 1'b0;
      m_ready = 1'b1;
      wait_drain("drain_bp");
      check("bp_pair_count", 32'(pair_count), 32'd5);

      // Overlong codeword
      force_miss = 1'b1;
      send_bits(32'h7FFFF, 19);
      errs = 0;
      @(negedge clk);
      check("overlong_len_full", 32'(lut_len), 32'd19);
      if (err_overlong) errs++;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (err_overlong) errs++;
      end
      check("overlong_pulse_cycles", 32'(errs), 32'd1);
      check("overlong_len_clear", 32'(lut_len), 32'd0);
      force_miss = 1'b0;
      @(posedge clk); #1;

      // Reset while reading the x escape
      linbits = 4'd4;
      send_bits(32'b01_0, 3);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst2_x_val", 32'(x_val), 32'd0);
      check("rst2_m_valid", 32'(m_valid), 32'd0);
      check("rst2_pair_count", 32'(pair_count), 32'd0);
      check("rst2_lut_len", 32'(lut_len), 32'd0);
      check("rst2_s_ready", 32'(s_ready), 32'd1);
      @(posedge clk); #1;
      exp_q.push_back({16'h0000, 16'h0000});
      send_bits(32'b1, 1);
      wait_drain("drain_after_rst");
      check("rst2_pair_count_after", 32'(pair_count), 32'd1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
